sr_drive_ctrl: RTL and testbench
================================

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a synchronized input is accepted (legal range 2..255).
REQ-002 SHALL have parameter PULSE_WIDTH, default 2: number of cycles enable plus S or R are driven (legal range 1..15).
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 4: number of idle cycles after each pulse (legal range 0..15).
REQ-004 SHALL have parameter CNT_W, default 8: width of the event counter.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 set_in  input  1  raw, asynchronous set request (button level).
REQ-008 clr_in  input  1  raw, asynchronous clear request (button level).
REQ-009 enable  output  1  latch enable for the downstream SR latch.
REQ-010 S  output  1  set drive to the latch.
REQ-011 R  output  1  reset drive to the latch.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 conflict  output  1  one-cycle pulse when set and clear requests arrive in the same cycle.
REQ-014 evt_cnt  output  CNT_W  count of pulses issued.

Function
REQ-015 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-016 Each synchronized input SHALL have its own debounced level and counter:
- Counter clears whenever the synchronized value equals the debounced level.
- Counter increments whenever the two differ.
- Debounced level toggles in the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter clears.
REQ-017 A request SHALL be a 0->1 transition of a debounced level, one cycle wide; falling transitions SHALL generate nothing.
REQ-018 FSM states SHALL be IDLE, PULSE and HOLDOFF, with one shared width/holdoff counter.
REQ-019 IDLE transitions:
- With exactly one request: load the counter, go to PULSE, latch the direction (set or clear).
- With both requests in the same cycle: stay in IDLE, pulse conflict for one cycle.
REQ-020 In PULSE, enable SHALL be 1 and S=1/R=0 (set) or S=0/R=1 (clear) for exactly PULSE_WIDTH cycles; then go to HOLDOFF, or to IDLE if HOLDOFF_CYCLES=0.
REQ-021 In HOLDOFF, enable, S and R SHALL be 0 for exactly HOLDOFF_CYCLES cycles; then go to IDLE.
REQ-022 Requests arriving in PULSE or HOLDOFF SHALL be dropped, not queued; a conflict in those states SHALL NOT pulse conflict.
REQ-023 S and R SHALL never both be 1, and neither SHALL be 1 while enable is 0.
REQ-024 evt_cnt SHALL increment by 1 on each IDLE->PULSE transition and wrap from 2^CNT_W-1 to 0.
REQ-025 Latency: the first PULSE cycle SHALL occur 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after a clean raw rising edge, with all outputs registered.

Reset
REQ-026 While rst=1, and in the cycle after its release, the FSM SHALL be IDLE with enable=S=R=busy=conflict=0 and evt_cnt=0.
REQ-027 Synchronizers, debounced levels and debounce counters SHALL reset to 0.
REQ-028 Reset asserted mid-PULSE SHALL drop enable/S/R immediately (asynchronously), with no pulse completion after release.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and the direction encoding (DIR_SET, DIR_CLR).
REQ-030 A sub-module debounce_sync SHALL contain one synchronizer, one debounce counter and the rising-edge detector; it SHALL be instantiated twice.

Verification
REQ-031 set_in held high from cycle 10, defaults -> enable=S=1 for 2 cycles starting cycle 29, busy high 6 cycles, evt_cnt=1.
REQ-032 clr_in glitch of 5 cycles high, then low -> no pulse, evt_cnt unchanged.
REQ-033 set_in and clr_in rising on the same edge, held -> conflict=1 for one cycle, enable never asserted.
REQ-034 clr_in rises 2 cycles after a set pulse begins -> set pulse completes, clear dropped, evt_cnt=1.
REQ-035 256 alternating set/clear presses with CNT_W=8 -> evt_cnt wraps to 0 and S/R alternate without overlap.
REQ-036 rst pulsed during the second PULSE cycle -> enable/S/R go to 0 asynchronously and the FSM is IDLE after release.

Source files
------------

// File: rtl/sr_drive_ctrl_pkg.sv
// Shared types for the SR latch drive controller: FSM states, pulse direction
// and internal counter widths.
package sr_drive_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  typedef enum logic {
    DIR_SET = 1'b0,
    DIR_CLR = 1'b1
  } dir_e;

  // Shared pulse-width / holdoff timer; both limits are at most 15.
  localparam int TMR_W = 4;
  // Debounce counter; DEBOUNCE_CYCLES is at most 255.
  localparam int DEB_CNT_W = 8;

endpackage

// File: rtl/sr_drive_ctrl_debounce_sync.sv
// One raw button input: two-flop synchronizer, debounce counter/level and a
// registered one-cycle pulse on each debounced 0->1 transition.
module debounce_sync
  import sr_drive_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic rise
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 deb_q, deb_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 rise_q, rise_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    // Any cycle matching the current level restarts the stability count.
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// SR latch drive controller: debounced set/clear buttons produce a fixed-width
// enable+S or enable+R pulse followed by a holdoff, and count issued pulses.
module sr_drive_ctrl
  import sr_drive_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_WIDTH     = 2,
  parameter int HOLDOFF_CYCLES  = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_in,
  input  logic             clr_in,
  output logic             enable,
  output logic             S,
  output logic             R,
  output logic             busy,
  output logic             conflict,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [TMR_W-1:0] PW_LOAD = TMR_W'(PULSE_WIDTH - 1);
  localparam logic [TMR_W-1:0] HO_LOAD =
    TMR_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

  logic set_rise;
  logic clr_rise;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk    (clk),
    .rst    (rst),
    .raw_in (set_in),
    .rise   (set_rise)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk    (clk),
    .rst    (rst),
    .raw_in (clr_in),
    .rise   (clr_rise)
  );

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   evt_q, evt_d;
  logic               enable_q, enable_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               busy_q, busy_d;
  logic               conflict_q, conflict_d;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    tmr_d      = tmr_q;
    evt_d      = evt_q;
    conflict_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (set_rise && clr_rise) begin
          conflict_d = 1'b1;
        end else if (set_rise || clr_rise) begin
          state_d = ST_PULSE;
          tmr_d   = PW_LOAD;
          dir_d   = set_rise ? DIR_SET : DIR_CLR;
          evt_d   = evt_q + 1'b1;
        end
      end
      ST_PULSE: begin
        if (tmr_q == '0) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            tmr_d   = HO_LOAD;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave a flop directly.
    enable_d = (state_d == ST_PULSE);
    s_d      = enable_d && (dir_d == DIR_SET);
    r_d      = enable_d && (dir_d == DIR_CLR);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_SET;
      tmr_q      <= '0;
      evt_q      <= '0;
      enable_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tmr_q      <= tmr_d;
      evt_q      <= evt_d;
      enable_q   <= enable_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign enable   = enable_q;
  assign S        = s_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;
  assign evt_cnt  = evt_q;

  a_no_overlap : assert property (@(posedge clk) disable iff (rst) !(s_q && r_q));
  a_drive_needs_enable : assert property (@(posedge clk) disable iff (rst)
                                          (s_q || r_q) |-> enable_q);

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: table of button-press scenarios with a queue of
// expected pulses, plus wrap-around and mid-pulse reset sequences.
module tb_sr_drive_ctrl;

  localparam int PW  = 2;
  localparam int HO  = 4;
  localparam int LAT = 2 + 16 + 1;

  logic       clk;
  logic       rst;
  logic       set_in;
  logic       clr_in;
  logic       enable;
  logic       S;
  logic       R;
  logic       busy;
  logic       conflict;
  logic [7:0] evt_cnt;

  sr_drive_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .set_in   (set_in),
    .clr_in   (clr_in),
    .enable   (enable),
    .S        (S),
    .R        (R),
    .busy     (busy),
    .conflict (conflict),
    .evt_cnt  (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dir_clr;
    logic [7:0] evt;
  } exp_t;

  typedef struct {
    bit do_set;
    bit do_clr;
    int clr_off;
    int hold;
    bit exp_set;
    bit exp_clr;
    int exp_conf;
  } vec_t;

  exp_t       q[$];
  logic [7:0] exp_evt;
  int         n_chk;
  int         n_fail;
  int         cyc;
  int         inv_err;
  int         conf_seen;
  int         t_en;
  int         pw;
  int         bl;
  logic       en_prev;
  logic       busy_prev;
  logic       pulse_s;
  logic       pulse_r;
  bit         sb_off;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic dir_clr);
    exp_t e;
    exp_evt   = exp_evt + 8'd1;
    e.dir_clr = dir_clr;
    e.evt     = exp_evt;
    q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (S === 1'b1 && R === 1'b1) inv_err++;
    if ((S === 1'b1 || R === 1'b1) && enable !== 1'b1) inv_err++;
    if (sb_off) begin
      en_prev   = enable;
      busy_prev = busy;
      pw        = 0;
      bl        = 0;
      return;
    end
    if (conflict === 1'b1) conf_seen++;
    if (enable === 1'b1) begin
      if (en_prev !== 1'b1) begin
        if (t_en < 0) t_en = cyc;
        pulse_s = S;
        pulse_r = R;
        pw      = 0;
      end
      pw++;
    end else if (en_prev === 1'b1) begin
      chk("pulse_width", pw, PW);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got S=%0d R=%0d expected no pulse", pulse_s, pulse_r);
      end else begin
        e = q.pop_front();
        chk("pulse_S", pulse_s, !e.dir_clr);
        chk("pulse_R", pulse_r, e.dir_clr);
        chk("evt_cnt", evt_cnt, e.evt);
      end
    end
    if (busy === 1'b1) begin
      bl++;
    end else if (busy_prev === 1'b1) begin
      chk("busy_len", bl, PW + HO);
      bl = 0;
    end
    en_prev   = enable;
    busy_prev = busy;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_enable"}, enable, 0);
    chk({tag, "_S"}, S, 0);
    chk({tag, "_R"}, R, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_conflict"}, conflict, 0);
    chk({tag, "_evt_cnt"}, evt_cnt, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int t_start;
    conf_seen = 0;
    t_en      = -1;
    if (v.exp_set) push_exp(1'b0);
    if (v.exp_clr) push_exp(1'b1);
    t_start = cyc;
    for (int t = 0; t < v.hold + v.clr_off; t++) begin
      set_in = v.do_set && (t < v.hold);
      clr_in = v.do_clr && (t >= v.clr_off) && (t < v.clr_off + v.hold);
      step();
    end
    set_in = 1'b0;
    clr_in = 1'b0;
    repeat (70) step();
    chk($sformatf("v%0d_conflict_cycles", idx), conf_seen, v.exp_conf);
    chk($sformatf("v%0d_pending_pulses", idx), q.size(), 0);
    if (idx == 0) chk("first_pulse_latency", t_en - t_start, LAT);
    q.delete();
  endtask

  vec_t vecs[10];

  initial begin
    bit got;
    n_chk   = 0;
    n_fail  = 0;
    cyc     = 0;
    inv_err = 0;
    exp_evt = 8'd0;
    en_prev = 1'b0;
    busy_prev = 1'b0;
    pw      = 0;
    bl      = 0;
    t_en    = -1;
    sb_off  = 1'b0;
    rst     = 1'b1;
    set_in  = 1'b0;
    clr_in  = 1'b0;

    //        set  clr  off hold  eS  eC  conf
    vecs[0] = '{1'b1, 1'b0, 0, 30, 1'b1, 1'b0, 0};  // clean set press
    vecs[1] = '{1'b0, 1'b1, 0, 30, 1'b0, 1'b1, 0};  // clean clear press
    vecs[2] = '{1'b0, 1'b1, 0, 5,  1'b0, 1'b0, 0};  // short clear glitch
    vecs[3] = '{1'b1, 1'b0, 0, 15, 1'b0, 1'b0, 0};  // one cycle short of stable
    vecs[4] = '{1'b1, 1'b0, 0, 16, 1'b1, 1'b0, 0};  // exactly stable long enough
    vecs[5] = '{1'b1, 1'b1, 0, 30, 1'b0, 1'b0, 1};  // simultaneous press
    vecs[6] = '{1'b1, 1'b1, 2, 30, 1'b1, 1'b0, 0};  // clear during pulse dropped
    vecs[7] = '{1'b1, 1'b1, 1, 30, 1'b1, 1'b0, 0};  // clear on first pulse cycle
    vecs[8] = '{1'b1, 1'b1, 6, 30, 1'b1, 1'b0, 0};  // clear in last holdoff cycle
    vecs[9] = '{1'b1, 1'b1, 7, 30, 1'b1, 1'b1, 0};  // clear just after return to idle

    repeat (3) step();
    check_idle("in_reset");
    rst = 1'b0;
    step();
    check_idle("after_reset");

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Counter wrap with alternating directions, from a fresh reset.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    exp_evt = 8'd0;
    step();
    chk("wrap_start_evt", evt_cnt, 0);
    for (int i = 0; i < 256; i++) begin
      push_exp(i[0]);
      for (int t = 0; t < 20; t++) begin
        set_in = !i[0];
        clr_in = i[0];
        step();
      end
      set_in = 1'b0;
      clr_in = 1'b0;
      repeat (45) step();
    end
    chk("wrap_evt_cnt", evt_cnt, 0);
    chk("wrap_pending", q.size(), 0);
    q.delete();

    // Asynchronous reset in the second cycle of a set pulse.
    sb_off = 1'b1;
    set_in = 1'b1;
    got    = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (enable === 1'b1) got = 1'b1;
    end
    chk("rst_test_pulse_seen", got, 1);
    step();
    chk("rst_test_cycle2_enable", enable, 1);
    rst    = 1'b1;
    set_in = 1'b0;
    #1;
    chk("async_rst_enable", enable, 0);
    chk("async_rst_S", S, 0);
    chk("async_rst_R", R, 0);
    chk("async_rst_busy", busy, 0);
    step();
    step();
    rst = 1'b0;
    step();
    check_idle("post_async_rst");
    exp_evt = 8'd0;
    q.delete();
    sb_off = 1'b0;
    repeat (60) step();
    chk("post_rst_no_pulse_evt", evt_cnt, 0);

    chk("sr_invariant_violations", inv_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
